// File: rtl/mul_mac_rr_sched_if.sv
// Request/response bundle for mul_mac_rr_sched: NREQ operand streams in,
// one tagged accumulated-sum response out.
interface mul_mac_rr_sched_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2,
  parameter int ACCW = 24
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*8-1:0] req_a;
  logic [NREQ*8-1:0] req_b;
  logic [NREQ-1:0]   req_last;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [ACCW-1:0]   rsp_data;

  // Requester/consumer side
  modport master (
    output req_valid, req_a, req_b, req_last, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data
  );

  // Scheduler side
  modport slave (
    input  req_valid, req_a, req_b, req_last, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data
  );
endinterface

// File: rtl/mul_mac_rr_sched.sv
// Round-robin shared signed 8x8 multiply-accumulate: one accumulator per
// requester, completed dot products returned on a single tagged response port.
module mul_mac_rr_sched #(
  parameter int NREQ = 4,
  parameter int IDW  = 2,
  parameter int ACCW = 24
) (
  input  logic              clock,
  input  logic              reset,
  mul_mac_rr_sched_if.slave bus
);

  logic [IDW-1:0]         rr_ptr;
  logic                   win_found;
  logic [IDW-1:0]         win_id;
  logic                   stall;
  logic                   advance;
  logic                   fire;

  logic                   s1_valid;
  logic [IDW-1:0]         s1_id;
  logic signed [7:0]      s1_a;
  logic signed [7:0]      s1_b;
  logic                   s1_last;

  logic signed [ACCW-1:0] acc [NREQ];
  logic signed [15:0]     prod;
  logic signed [ACCW-1:0] prod_ext;
  logic signed [ACCW-1:0] sum;
  logic                   s1_done;

  logic                   rsp_valid_q;
  logic [IDW-1:0]         rsp_id_q;
  logic [ACCW-1:0]        rsp_data_q;

  // S1 may only be frozen by a last pair that cannot hand off its result
  assign stall   = s1_valid & s1_last & rsp_valid_q & ~bus.rsp_ready;
  assign advance = ~stall;
  assign fire    = win_found & advance & ~reset;
  assign s1_done = advance & s1_valid;

  // Round-robin search from rr_ptr; IDW-bit addition wraps modulo NREQ
  always_comb begin
    logic [IDW-1:0] cand;
    win_found = 1'b0;
    win_id    = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = rr_ptr + IDW'(k);
      if (!win_found && bus.req_valid[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
  end

  // One-hot grant, independent of operand data
  always_comb begin
    bus.req_ready = '0;
    if (fire) begin
      bus.req_ready[win_id] = 1'b1;
    end
  end

  // Shared multiplier and accumulate path for the pair held in S1
  always_comb begin
    prod     = s1_a * s1_b;
    prod_ext = ACCW'(prod);
    sum      = acc[s1_id] + prod_ext;
  end

  // Grant/capture stage into the S1 operand register and pointer update
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_id    <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_last  <= 1'b0;
      rr_ptr   <= '0;
    end else if (advance) begin
      if (fire) begin
        s1_valid <= 1'b1;
        s1_id    <= win_id;
        s1_a     <= bus.req_a[win_id*8 +: 8];
        s1_b     <= bus.req_b[win_id*8 +: 8];
        s1_last  <= bus.req_last[win_id];
        rr_ptr   <= win_id + IDW'(1);
      end else begin
        s1_valid <= 1'b0;
      end
    end
  end

  // Per-requester accumulators; a closing pair restarts its accumulator
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        acc[i] <= '0;
      end
    end else if (s1_done) begin
      acc[s1_id] <= s1_last ? '0 : sum;
    end
  end

  // Response register; a new completion may replace one accepted this cycle
  always_ff @(posedge clock) begin
    if (reset) begin
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
    end else if (s1_done && s1_last) begin
      rsp_valid_q <= 1'b1;
      rsp_id_q    <= s1_id;
      rsp_data_q  <= sum;
    end else if (bus.rsp_ready) begin
      rsp_valid_q <= 1'b0;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_mul_mac_rr_sched.sv
// Directed scoreboard bench for mul_mac_rr_sched; a 16-bit-accumulator copy
// sees identical traffic to exercise wrap-around.
module tb_mul_mac_rr_sched;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  mul_mac_rr_sched_if #(.NREQ(NREQ), .IDW(IDW), .ACCW(24)) bus ();
  mul_mac_rr_sched_if #(.NREQ(NREQ), .IDW(IDW), .ACCW(16)) bus16 ();

  assign bus16.req_valid = bus.req_valid;
  assign bus16.req_a     = bus.req_a;
  assign bus16.req_b     = bus.req_b;
  assign bus16.req_last  = bus.req_last;
  assign bus16.rsp_ready = bus.rsp_ready;

  mul_mac_rr_sched #(.NREQ(NREQ), .IDW(IDW), .ACCW(24)) dut (
    .clock(clock), .reset(reset), .bus(bus)
  );
  mul_mac_rr_sched #(.NREQ(NREQ), .IDW(IDW), .ACCW(16)) dut16 (
    .clock(clock), .reset(reset), .bus(bus16)
  );

  typedef struct { int id; int data; } exp_t;
  exp_t q24[$];
  exp_t q16[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic expect_rsp(input int id, input int d24, input int d16);
    exp_t e;
    e.id = id; e.data = d24; q24.push_back(e);
    e.data = d16;            q16.push_back(e);
  endtask

  // Response monitors: pop and compare on every accepted response
  always @(negedge clock) begin
    exp_t e;
    if (!reset && bus.rsp_valid && bus.rsp_ready) begin
      if (q24.size() == 0) begin
        chk("rsp24_unexpected_id", int'(bus.rsp_id), -1);
      end else begin
        e = q24.pop_front();
        chk("rsp24_id", int'(bus.rsp_id), e.id);
        chk("rsp24_data", int'($signed(bus.rsp_data)), e.data);
      end
    end
  end

  always @(negedge clock) begin
    exp_t e;
    if (!reset && bus16.rsp_valid && bus16.rsp_ready) begin
      if (q16.size() == 0) begin
        chk("rsp16_unexpected_id", int'(bus16.rsp_id), -1);
      end else begin
        e = q16.pop_front();
        chk("rsp16_id", int'(bus16.rsp_id), e.id);
        chk("rsp16_data", int'($signed(bus16.rsp_data)), e.data);
      end
    end
  end

  task automatic step();
    @(posedge clock); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic set_pair(input int id, input int a, input int b, input bit last);
    bus.req_a[id*8 +: 8] = 8'(a);
    bus.req_b[id*8 +: 8] = 8'(b);
    bus.req_last[id]     = last;
  endtask

  // Present one pair on requester id until granted (bounded)
  task automatic send(input int id, input int a, input int b, input bit last);
    int n;
    set_pair(id, a, b, last);
    bus.req_valid[id] = 1'b1;
    n = 0;
    @(negedge clock);
    while (!bus.req_ready[id] && n < 40) begin
      @(negedge clock);
      n++;
    end
    chk("send_grant", int'(bus.req_ready[id]), 1);
    step();
    bus.req_valid[id] = 1'b0;
    bus.req_last[id]  = 1'b0;
  endtask

  initial begin
    #100000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1);
  end

  initial begin
    reset         = 1'b1;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_last  = '0;
    bus.rsp_ready = 1'b1;
    idle(2);

    // Reset state, with requests present during reset
    bus.req_valid = '1;
    @(negedge clock);
    chk("rst_rsp_valid", int'(bus.rsp_valid), 0);
    chk("rst_rsp_id", int'(bus.rsp_id), 0);
    chk("rst_rsp_data", int'(bus.rsp_data), 0);
    chk("rst_req_ready", int'(bus.req_ready), 0);
    bus.req_valid = '0;
    step();
    reset = 1'b0;

    // Requester 0 dot product: 12 - 10 - 7 = -5, latency two cycles
    expect_rsp(0, -5, -5);
    send(0, 3, 4, 0);
    send(0, -2, 5, 0);
    send(0, 7, -1, 1);
    @(negedge clock);
    chk("lat_t1_valid", int'(bus.rsp_valid), 0);
    @(negedge clock);
    chk("lat_t2_valid", int'(bus.rsp_valid), 1);
    step();

    // Rotation 0,1,2,3,0,1 with all requesters valid
    do_reset();
    for (int i = 0; i < NREQ; i++) set_pair(i, 1, 1, 0);
    bus.req_valid = '1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      chk("rotate_grant", int'(bus.req_ready), 1 << (k % 4));
      step();
    end
    // rr_ptr is now 2: only 0 and 3 valid, 3 must win first
    expect_rsp(3, 2, 2);
    expect_rsp(0, 3, 3);
    bus.req_valid = 4'b1001;
    bus.req_last  = 4'b1001;
    @(negedge clock);
    chk("rr_wrap_grant3", int'(bus.req_ready), 4'b1000);
    step();
    bus.req_valid[3] = 1'b0;
    bus.req_last[3]  = 1'b0;
    @(negedge clock);
    chk("rr_wrap_grant0", int'(bus.req_ready), 4'b0001);
    step();
    bus.req_valid = '0;
    bus.req_last  = '0;
    expect_rsp(1, 3, 3);
    send(1, 1, 1, 1);
    expect_rsp(2, 2, 2);
    send(2, 1, 1, 1);
    idle(3);

    // Product corners and accumulator wrap (5 * 16384)
    expect_rsp(1, 81920, 16384);
    for (int k = 0; k < 4; k++) send(1, -128, -128, 0);
    send(1, -128, -128, 1);
    expect_rsp(0, -16256, -16256);
    send(0, -128, 127, 1);
    idle(4);

    // Blocked response: S1 freezes on req1's last pair
    do_reset();
    bus.rsp_ready = 1'b0;
    expect_rsp(0, 25, 25);
    expect_rsp(1, 36, 36);
    set_pair(0, 5, 5, 1);
    set_pair(1, 6, 6, 1);
    bus.req_valid = 4'b0011;
    @(negedge clock);
    chk("stall_grant0", int'(bus.req_ready), 4'b0001);
    step();
    bus.req_valid[0] = 1'b0;
    bus.req_last[0]  = 1'b0;
    @(negedge clock);
    chk("stall_grant1", int'(bus.req_ready), 4'b0010);
    step();
    bus.req_valid[1] = 1'b0;
    bus.req_last[1]  = 1'b0;
    set_pair(2, 2, 3, 0);
    bus.req_valid[2] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      chk("stall_ready", int'(bus.req_ready), 0);
      chk("stall_rsp_valid", int'(bus.rsp_valid), 1);
      chk("stall_rsp_id", int'(bus.rsp_id), 0);
      chk("stall_rsp_data", int'($signed(bus.rsp_data)), 25);
      step();
    end
    bus.rsp_ready = 1'b1;
    @(negedge clock);
    chk("unstall_grant2", int'(bus.req_ready), 4'b0100);
    step();
    bus.req_valid[2] = 1'b0;
    @(negedge clock);
    chk("b2b_rsp_valid", int'(bus.rsp_valid), 1);
    chk("b2b_rsp_id", int'(bus.rsp_id), 1);
    chk("b2b_rsp_data", int'($signed(bus.rsp_data)), 36);
    step();

    // Mid-operation reset discards req2's partial sum of 40
    send(2, 17, 2, 0);
    idle(2);
    do_reset();
    @(negedge clock);
    chk("midrst_rsp_valid", int'(bus.rsp_valid), 0);
    chk("midrst_rsp_id", int'(bus.rsp_id), 0);
    chk("midrst_rsp_data", int'(bus.rsp_data), 0);
    step();
    expect_rsp(2, 1, 1);
    send(2, 1, 1, 1);
    idle(4);

    // Back-to-back single-pair vectors from all requesters
    do_reset();
    set_pair(0, 1, 2, 1);
    set_pair(1, 3, 4, 1);
    set_pair(2, 5, 6, 1);
    set_pair(3, 7, -8, 1);
    expect_rsp(0, 2, 2);
    expect_rsp(1, 12, 12);
    expect_rsp(2, 30, 30);
    expect_rsp(3, -56, -56);
    bus.req_valid = '1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      if (k < 4) chk("bb_grant", int'(bus.req_ready), 1 << k);
      if (k >= 2) begin
        chk("bb_rsp_valid", int'(bus.rsp_valid), 1);
        chk("bb_rsp_id", int'(bus.rsp_id), k - 2);
      end
      step();
      if (k < 4) begin
        bus.req_valid[k] = 1'b0;
        bus.req_last[k]  = 1'b0;
      end
    end
    @(negedge clock);
    chk("bb_rsp_idle", int'(bus.rsp_valid), 0);
    idle(5);

    chk("sb24_drained", q24.size(), 0);
    chk("sb16_drained", q16.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_mac_rr_sched.md
Name: mul_mac_rr_sched

Overview:
- Shares one signed 8x8 multiplier (the existing `mul` block) between NREQ requesters using round-robin arbitration.
- Keeps one signed accumulator per requester, so each requester gets a dot-product engine.
- A requester streams operand pairs and flags the last pair of a vector. The block then returns that requester's accumulated sum, tagged with its id, on a single shared valid/ready response port.
- Sits between PE-column drain logic and the output buffer of the WS systolic array.

Parameters:
- NREQ, 4, number of requesters (power of two, 2..8).
- IDW, 2, requester id width; must equal log2(NREQ).
- ACCW, 24, accumulator and response width in bits (>=16).

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  bit i: requester i presents an operand pair.
- req_ready  out  NREQ  bit i: requester i's pair is accepted this cycle; at most one bit is set.
- req_a  in  NREQ*8  slice [8i+7:8i]: signed operand A of requester i.
- req_b  in  NREQ*8  slice [8i+7:8i]: signed operand B of requester i.
- req_last  in  NREQ  bit i: this pair closes requester i's vector.
- rsp_valid  out  1  response holds a completed sum.
- rsp_ready  in  1  consumer accepts the response.
- rsp_id  out  IDW  requester that owns the response.
- rsp_data  out  ACCW  signed accumulated sum.

Behaviour:
- Reset: rsp_valid=0, rsp_id=0, rsp_data=0, req_ready=0. Internally: s1_valid=0, every acc[i]=0, rr_ptr=0.
- Reset mid-operation discards S1 contents, all partial sums and any pending response; the next cycle behaves as after power-up.
- Pipeline: the grant/capture stage (S0) feeds operand register S1, which holds valid, id, a, b and last. The multiply and accumulate happen combinationally in S1 and are written back at the clock edge.
- stall = s1_valid & s1_last & rsp_valid & ~rsp_ready.
- advance = ~stall.
- Arbitration (combinational):
  - Search requesters starting at rr_ptr, wrapping modulo NREQ; the first one with req_valid set wins.
  - req_ready[win] = advance; all other req_ready bits are 0.
  - No winner, or stall: all req_ready bits are 0.
  - req_ready must not depend on req_a, req_b or req_last.
- On fire (req_valid[i] & req_ready[i]):
  - S1 captures {i, a_i, b_i, last_i}.
  - rr_ptr <= (i+1) mod NREQ.
- If advance and there is no fire, s1_valid <= 0.
- S1 completion, when advance & s1_valid:
  - p = signed 16-bit product, sign-extended to ACCW.
  - sum = acc[id] + p, wrapping modulo 2^ACCW (no saturation).
  - If last=0: acc[id] <= sum.
  - If last=1: acc[id] <= 0, rsp_valid <= 1, rsp_id <= id, rsp_data <= sum.
- Response register:
  - Cleared (rsp_valid <= 0) when rsp_ready=1 and no new last completes in the same cycle.
  - rsp_id and rsp_data hold their values while rsp_valid=1 and rsp_ready=0.
  - A new completion may overwrite the register in the same cycle the old response is accepted; this is back-to-back throughput.
- Latency: a pair accepted in cycle T is accumulated at the end of T+1. A last pair accepted in T gives rsp_valid=1 from T+2.
- Throughput: one pair per cycle with no bubbles while rsp_ready=1.
- Stall behaviour:
  - A non-last pair in S1 still completes while the response is blocked.
  - Only a last pair in S1 with the response occupied freezes S1 and holds all req_ready bits at 0.
- Non-last pairs of different requesters may interleave freely; each acc[i] is touched only by its own requester.
- If a requester drops req_valid mid-vector, its partial sum is kept indefinitely.
- Single-element vector (last=1 on the first pair): response = product.
- Product corners: -128*-128 = +16384 and -128*127 = -16256 must be exact.

Test Plan:
- Single requester 0 sends (3,4),(-2,5),(7,-1,last), rsp_ready=1 -> one response: id=0, data=12-10-7=-5, appearing 2 cycles after the last pair is accepted.
- All 4 requesters hold valid with no last -> grants rotate 0,1,2,3,0; each pair gets ready exactly once per 4 cycles; with rr_ptr=2 and only requesters 0 and 3 valid, 3 is granted first.
- Requester 1 sends (-128,-128) 4 times then (-128,-128,last), ACCW=24 -> data=81920; with ACCW=16 -> data wraps to 16384.
- rsp_ready=0 while req0 and req1 each send a single last pair (5,5) and (6,6) -> first response id=0 data=25 holds; S1 freezes on req1; all req_ready=0 until rsp_ready=1; then id=1 data=36 follows in the next cycle.
- Reset asserted for 1 cycle while req2 has a partial sum of 40 -> outputs return to 0; a later single (1,1,last) from req2 yields data=1.
- Back-to-back last pairs from req0..req3, rsp_ready=1 -> 4 consecutive rsp_valid cycles, ids 0,1,2,3, no bubbles.
